// File: rtl/otter_cdb_pkg.sv
// Shared constants and the registered CDB packet type for the result-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package otter_cdb_pkg;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    // Functional-unit indices, matching the requester slice order on the arbiter ports
    localparam logic [1:0] FU_ALU  = 2'd0;
    localparam logic [1:0] FU_BR   = 2'd1;
    localparam logic [1:0] FU_LDST = 2'd2;
    localparam logic [1:0] FU_MUL  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        src;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_mux4.sv
// Generic 4-input result mux, W bits wide, 2-bit select.
// Latency: combinational.
// Backpressure: none.
module mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    // Plain select; every input combination is covered so no latch can form
    always_comb begin
        unique case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin winner search over four requests, starting at ptr.
// Latency: combinational.
// Backpressure: en=0 forces no winner (used to squash arbitration on flush).
module rr_picker
    import otter_cdb_pkg::*;
(
    input  logic [NUM_FU-1:0] req,
    input  logic [1:0]        ptr,
    input  logic              en,
    output logic [NUM_FU-1:0] onehot,
    output logic [1:0]        idx,
    output logic              any
);

    logic [1:0] cand;

    // Scan ptr, ptr+1, ... (2-bit wrap) and keep the first set request
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        if (en) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cand = ptr + 2'(k);
                if (!any && req[cand]) begin
                    any = 1'b1;
                    idx = cand;
                end
            end
        end
        if (any) begin
            onehot = NUM_FU'(1) << idx;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among ALU, branch, load/store and multiply results.
// Latency: grant is combinational; broadcast appears on the CDB one edge after the grant.
// Backpressure: requesters hold valid/tag/data until req_ready; flush withholds all grants.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [1:0]                cdb_src
);

    otter_cdb_pkg::cdb_pkt_t pkt_q, pkt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        win_idx;
    logic              win_any;
    logic [TAG_W-1:0]  tag_sel;
    logic [DATA_W-1:0] data_sel;

    rr_picker u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (~flush),
        .onehot (req_ready),
        .idx    (win_idx),
        .any    (win_any)
    );

    mux4 #(.W(DATA_W)) u_data_mux (
        .in0 (req_data[0*DATA_W +: DATA_W]),
        .in1 (req_data[1*DATA_W +: DATA_W]),
        .in2 (req_data[2*DATA_W +: DATA_W]),
        .in3 (req_data[3*DATA_W +: DATA_W]),
        .sel (win_idx),
        .out (data_sel)
    );

    mux4 #(.W(TAG_W)) u_tag_mux (
        .in0 (req_tag[0*TAG_W +: TAG_W]),
        .in1 (req_tag[1*TAG_W +: TAG_W]),
        .in2 (req_tag[2*TAG_W +: TAG_W]),
        .in3 (req_tag[3*TAG_W +: TAG_W]),
        .sel (win_idx),
        .out (tag_sel)
    );

    // Next broadcast: winner's result if any grant, else drop valid and keep payload/pointer
    always_comb begin
        pkt_d       = pkt_q;
        pkt_d.valid = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        if (win_any) begin
            pkt_d.valid = 1'b1;
            pkt_d.tag   = tag_sel;
            pkt_d.data  = data_sel;
            pkt_d.src   = win_idx;
            rr_ptr_d    = win_idx + 2'd1;
        end
    end

    // Broadcast register and priority pointer; reset overrides flush and requests
    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            pkt_q    <= pkt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid = pkt_q.valid;
    assign cdb_tag   = pkt_q.tag;
    assign cdb_data  = pkt_q.data;
    assign cdb_src   = pkt_q.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed steps then randomized traffic.
// Latency: expects grant same cycle, broadcast one edge later.
// Backpressure: modeled requesters hold their result until granted.
module tb_cdb_arbiter;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush;
    logic [3:0]    req_valid;
    logic [19:0]   req_tag;
    logic [127:0]  req_data;
    logic [3:0]    req_ready;
    logic          cdb_valid;
    logic [4:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic [1:0]    cdb_src;

    cdb_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference state: priority pointer and the broadcast currently on the bus
    int          m_ptr;
    logic        m_v;
    logic [4:0]  m_tag;
    logic [31:0] m_data;
    logic [1:0]  m_src;

    // Random-phase requesters
    logic        pend [4];
    logic [4:0]  ptag [4];
    logic [31:0] pdat [4];
    int          waitc [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
        req_valid[i]         = v;
        req_tag[i*5 +: 5]    = t;
        req_data[i*32 +: 32] = d;
    endtask

    // One clock: check the grant mid-cycle, advance the model at the edge, check the bus after it
    task automatic cycle(output int w);
        logic [3:0] exp_rdy;
        #3;
        w = -1;
        if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
        end
        exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge CLK);
        #1;
        if (RST) begin
            m_ptr = 0; m_v = 0; m_tag = 0; m_data = 0; m_src = 0;
            w = -1;
        end else if (w >= 0) begin
            m_v    = 1'b1;
            m_tag  = req_tag[w*5 +: 5];
            m_data = req_data[w*32 +: 32];
            m_src  = 2'(w);
            m_ptr  = (w + 1) % 4;
        end else begin
            m_v = 1'b0;
        end
        chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
        chk("cdb_tag",   64'(cdb_tag),   64'(m_tag));
        chk("cdb_data",  64'(cdb_data),  64'(m_data));
        chk("cdb_src",   64'(cdb_src),   64'(m_src));
    endtask

    initial begin
        int w;
        RST = 1'b1; flush = 1'b0;
        req_valid = '0; req_tag = '0; req_data = '0;
        m_ptr = 0; m_v = 0; m_tag = 0; m_data = 0; m_src = 0;
        @(posedge CLK);
        #1;

        // Reset held with every requester valid: grant still points at FU0, bus stays zero
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 10), 32'hA000_0000 + 32'(i));
        for (int c = 0; c < 2; c++) begin
            cycle(w);
            chk("rst_ready", 64'(req_ready), 64'h1);
            chk("rst_valid", 64'(cdb_valid), 64'h0);
        end
        RST = 1'b0;

        // Full contention, 8 cycles: rotation 0,1,2,3,0,1,2,3
        for (int c = 0; c < 8; c++) begin
            cycle(w);
            chk("rot_src", 64'(cdb_src), 64'(c % 4));
            chk("rot_onehot", 64'($countones(req_ready) == 1), 64'h1);
        end

        // Single requester FU2 with tag 7 / DEADBEEF
        req_valid = '0;
        set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
        cycle(w);
        chk("single_ready", 64'(req_ready), 64'h4);
        chk("single_tag", 64'(cdb_tag), 64'd7);
        chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
        chk("single_src", 64'(cdb_src), 64'd2);

        // FU3 now highest priority but idle; FU0 then FU1 must win
        req_valid = '0;
        set_req(0, 1'b1, 5'd1, 32'h0000_0100);
        set_req(1, 1'b1, 5'd2, 32'h0000_0200);
        cycle(w);
        chk("wrap_src0", 64'(cdb_src), 64'd0);
        set_req(0, 1'b0, 5'd0, 32'h0);
        cycle(w);
        chk("wrap_src1", 64'(cdb_src), 64'd1);

        // Flush with FU1 valid: broadcast from previous grant still visible, nothing granted
        set_req(1, 1'b1, 5'd9, 32'h0000_0900);
        flush = 1'b1;
        #2;
        chk("flush_prev_bcast", 64'(cdb_valid), 64'h1);
        #1;
        chk("flush_ready_mid", 64'(req_ready), 64'h0);
        #2;
        cycle(w);
        chk("flush_squash", 64'(cdb_valid), 64'h0);
        flush = 1'b0;
        cycle(w);
        chk("post_flush_src", 64'(cdb_src), 64'd1);
        chk("post_flush_tag", 64'(cdb_tag), 64'd9);

        // Idle hold after a tag 3 / 0x1234 broadcast
        req_valid = '0;
        set_req(0, 1'b1, 5'd3, 32'h0000_1234);
        cycle(w);
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            cycle(w);
            chk("idle_valid", 64'(cdb_valid), 64'h0);
            chk("idle_tag", 64'(cdb_tag), 64'd3);
            chk("idle_data", 64'(cdb_data), 64'h1234);
        end

        // Randomized traffic: requesters hold until granted, occasional flushes
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; ptag[i] = '0; pdat[i] = '0; waitc[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    ptag[i] = 5'($urandom);
                    pdat[i] = $urandom;
                end
                set_req(i, pend[i], ptag[i], pdat[i]);
            end
            flush = ($urandom_range(0, 7) == 0);
            cycle(w);
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && i == w) begin
                    chk("fair_wait", 64'(waitc[i] <= 3), 64'h1);
                    pend[i] = 1'b0;
                    waitc[i] = 0;
                end else if (pend[i] && !flush) begin
                    waitc[i]++;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter sharing the single Common Data Bus (CDB) among the four functional-unit result ports of the out-of-order OTTER core: ALU, branch, load/store, multiply.
- Each cycle it grants at most one valid requester, steers that requester's tag/data through the 32-bit 4-input result mux, and registers the winner as a one-cycle CDB broadcast to the reservation stations and ROB.
- Supports a pipeline flush that squashes arbitration and any pending broadcast.

Parameters:
- NUM_REQ, 4: number of requesters; fixed at 4 to match the 2-bit mux select. Other values are unsupported.
- DATA_W, 32: result data width.
- TAG_W, 5: ROB tag width.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  squash; no grant this cycle; clears the broadcast next edge.
- req_valid  input  NUM_REQ  per-FU result valid; held until granted.
- req_tag  input  NUM_REQ*TAG_W  per-FU ROB tag; slice i = bits [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  per-FU result; slice i = bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  combinational one-hot grant; zero or one bit set.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.
- cdb_src  output  2  registered index of the broadcasting FU.

Behaviour:
- State:
  - rr_ptr (2 bits): index of the highest-priority requester.
  - CDB output registers.
- Reset, when RST=1 at an edge:
  - rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - RST has priority over flush and over requests.
- Grant (combinational):
  - If flush=0 and any req_valid is set, the winner is the first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - req_ready = one-hot(winner).
  - Otherwise req_ready=0.
  - req_ready depends only on req_valid, rr_ptr and flush. It never depends on req_tag or req_data.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1 in the same cycle.
  - A requester must keep valid, tag and data stable until it is granted.
  - After a grant the requester may drop valid or present a new result in the next cycle.
- Broadcast (registered, 1-cycle latency), at the edge following a grant:
  - cdb_valid=1, cdb_tag=req_tag[winner], cdb_data=req_data[winner], cdb_src=winner.
  - rr_ptr = (winner+1) mod 4; wrap 3 goes to 0.
- No valid requests and no flush:
  - cdb_valid=0; cdb_tag, cdb_data, cdb_src and rr_ptr hold their values.
- Flush=1:
  - req_ready=0 in that cycle.
  - At the next edge cdb_valid=0 and rr_ptr holds.
  - A broadcast already on the CDB in the flush cycle still completes in that cycle; only the following cycle is squashed.
- Back-to-back: a single requester that is continuously valid wins every cycle when the others are idle, giving one broadcast per cycle.
- Fairness: with all four requesters continuously valid, grants rotate 0,1,2,3,0,... A valid requester waits at most 3 cycles for a grant.
- Bus behaviour: the CDB is never stalled downstream; every registered broadcast is consumed in the cycle it is presented.
- Width rules: rr_ptr increments modulo 4 with no saturation. Tag and data pass through unmodified.

Decomposition:
- Package otter_cdb_pkg:
  - Constants: NUM_FU=4, TAG_W=5, and FU index constants FU_ALU=0, FU_BR=1, FU_LDST=2, FU_MUL=3.
  - Type cdb_pkt_t, a struct of {valid, tag[TAG_W], data[DATA_W], src[1:0]}, used for the registered output.
- Sub-module rr_picker:
  - Combinational.
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: onehot[3:0], idx[1:0], any.
- Data selection instantiates the team's existing 32-bit 4-input mux for data, with idx as its select. The tag is selected by an equivalent TAG_W-wide mux.

Test Plan:
- Reset with all inputs driven: RST=1 with req_valid=4'b1111 for 2 cycles -> req_ready is still one-hot (bit 0), and every registered output stays 0 while RST is held. After RST deasserts, the first broadcast has cdb_src=0.
- Single requester: req_valid=4'b0100, tag=5'd7, data=32'hDEADBEEF -> req_ready=4'b0100 in the same cycle. The next cycle gives cdb_valid=1, cdb_tag=7, cdb_data=32'hDEADBEEF, cdb_src=2, and rr_ptr=3.
- Full contention: all four valid for 8 cycles -> cdb_src sequence is 0,1,2,3,0,1,2,3, with exactly one req_ready bit set each cycle.
- Pointer skip and wrap: rr_ptr=3 with req_valid=4'b0011 -> FU0 is granted, then FU1. FU3 is never granted while its valid is 0.
- Flush: FU1 valid during a flush cycle -> req_ready=0, and the next cycle has cdb_valid=0 with rr_ptr unchanged. FU1 is granted the first cycle after flush deasserts.
- Idle hold: broadcast tag=3, data=32'h1234, then no valids for 3 cycles -> cdb_valid=0, while cdb_tag=3 and cdb_data=32'h1234 hold.
